// File: rtl/rgb_word_packer.sv
// rgb_word_packer
//   Packs a 24-bit RGB pixel stream into 32-bit AXI4-Stream words, four pixels
//   into three words with the pixel bytes contiguous, byte 0 in bits [7:0].
//   Start of frame is marked on tuser and end of line on tlast. A line that
//   ends part-way through a word is padded with PAD_BYTE and masked by tkeep.
//
// Ports
//   aclk, areset        clock and synchronous active-high reset
//   r, g, b             pixel bytes; the pixel is P = {r,g,b}
//   valid, sof, eol     pixel offered / first pixel of frame / last of line
//   in_stream_ready     packer takes the pixel on this edge
//   out_stream_*        registered AXI4-Stream output
//   sync_err            sticky: sof arrived in the middle of a pixel group
//   dbg_state           {in_flush, phase}
//
// Handshake: a pixel transfers on a rising edge where valid && in_stream_ready;
// a word transfers on a rising edge where out_stream_tvalid && out_stream_tready.
// Once tvalid is raised the word and its sideband stay unchanged until that
// transfer. in_stream_ready depends combinationally on out_stream_tready.

module rgb_word_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        valid,
  input  logic        sof,
  input  logic        eol,
  output logic        in_stream_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready,
  output logic        sync_err,
  output logic [2:0]  dbg_state
);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t      r_state;
  logic [1:0]  r_phase;
  logic [23:0] r_hold;
  logic        r_tuser_pending;
  logic        r_sync_err;
  logic [31:0] r_tdata;
  logic [3:0]  r_tkeep;
  logic        r_tlast;
  logic        r_tuser;
  logic        r_tvalid;
  logic [31:0] r_flush_data;
  logic [3:0]  r_flush_keep;

  logic        w_out_free;
  logic        w_accept;
  logic [23:0] w_pixel;
  logic [1:0]  w_phase;
  logic [23:0] w_hold;
  logic        w_emit;
  logic [31:0] w_word;
  logic [3:0]  w_keep;
  logic        w_last;
  logic [1:0]  w_next_phase;
  logic [23:0] w_next_hold;
  logic        w_go_flush;
  logic [31:0] w_flush_data;
  logic [3:0]  w_flush_keep;

  assign w_out_free      = !r_tvalid || out_stream_tready;
  assign in_stream_ready = (r_state == ST_RUN) && w_out_free;
  assign w_accept        = valid && in_stream_ready;
  assign w_pixel         = {r, g, b};

  // sof restarts the group: the pixel is treated as P0 and leftovers are dropped.
  assign w_phase = sof ? 2'd0 : r_phase;
  assign w_hold  = sof ? 24'h0 : r_hold;

  always_comb begin
    w_emit       = 1'b1;
    w_word       = '0;
    w_keep       = 4'hF;
    w_last       = 1'b0;
    w_next_phase = 2'd0;
    w_next_hold  = '0;
    w_go_flush   = 1'b0;
    w_flush_data = '0;
    w_flush_keep = '0;
    case (w_phase)
      2'd0: begin
        if (eol) begin
          w_word = {PAD_BYTE, w_pixel};
          w_keep = 4'b0111;
          w_last = 1'b1;
        end else begin
          w_emit       = 1'b0;
          w_next_phase = 2'd1;
          w_next_hold  = w_pixel;
        end
      end
      2'd1: begin
        w_word = {w_pixel[7:0], w_hold[23:0]};
        if (eol) begin
          w_go_flush   = 1'b1;
          w_flush_data = {PAD_BYTE, PAD_BYTE, w_pixel[23:8]};
          w_flush_keep = 4'b0011;
        end else begin
          w_next_phase = 2'd2;
          w_next_hold  = {8'h00, w_pixel[23:8]};
        end
      end
      2'd2: begin
        w_word = {w_pixel[15:0], w_hold[15:0]};
        if (eol) begin
          w_go_flush   = 1'b1;
          w_flush_data = {PAD_BYTE, PAD_BYTE, PAD_BYTE, w_pixel[23:16]};
          w_flush_keep = 4'b0001;
        end else begin
          w_next_phase = 2'd3;
          w_next_hold  = {16'h0000, w_pixel[23:16]};
        end
      end
      default: begin
        w_word = {w_pixel, w_hold[7:0]};
        w_last = eol;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state         <= ST_RUN;
      r_phase         <= 2'd0;
      r_hold          <= '0;
      r_tuser_pending <= 1'b0;
      r_sync_err      <= 1'b0;
      r_tdata         <= '0;
      r_tkeep         <= '0;
      r_tlast         <= 1'b0;
      r_tuser         <= 1'b0;
      r_tvalid        <= 1'b0;
      r_flush_data    <= '0;
      r_flush_keep    <= '0;
    end else begin
      if (r_tvalid && out_stream_tready) begin
        r_tvalid <= 1'b0;
      end
      case (r_state)
        ST_RUN: begin
          if (w_accept) begin
            r_phase <= w_next_phase;
            r_hold  <= w_next_hold;
            if (sof && (r_phase != 2'd0)) begin
              r_sync_err <= 1'b1;
            end
            if (w_emit) begin
              r_tvalid        <= 1'b1;
              r_tdata         <= w_word;
              r_tkeep         <= w_keep;
              r_tlast         <= w_last;
              r_tuser         <= r_tuser_pending || sof;
              r_tuser_pending <= 1'b0;
            end else if (sof) begin
              r_tuser_pending <= 1'b1;
            end
            if (w_go_flush) begin
              r_state      <= ST_FLUSH;
              r_flush_data <= w_flush_data;
              r_flush_keep <= w_flush_keep;
            end
          end
        end
        ST_FLUSH: begin
          // The full word from the eol pixel occupies the output first.
          if (w_out_free) begin
            r_tvalid        <= 1'b1;
            r_tdata         <= r_flush_data;
            r_tkeep         <= r_flush_keep;
            r_tlast         <= 1'b1;
            r_tuser         <= r_tuser_pending;
            r_tuser_pending <= 1'b0;
            r_state         <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign out_stream_tdata  = r_tdata;
  assign out_stream_tkeep  = r_tkeep;
  assign out_stream_tlast  = r_tlast;
  assign out_stream_tuser  = r_tuser;
  assign out_stream_tvalid = r_tvalid;
  assign sync_err          = r_sync_err;
  assign dbg_state         = {(r_state == ST_FLUSH), r_phase};

endmodule

// File: tb/tb_rgb_word_packer.sv
module tb_rgb_word_packer;

  localparam logic [7:0] PAD = 8'h00;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  r, g, b;
  logic        valid, sof, eol;
  logic        in_stream_ready;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tuser, tvalid, tready;
  logic        sync_err;
  logic [2:0]  dbg_state;

  rgb_word_packer #(.PAD_BYTE(PAD)) dut (
    .aclk(aclk), .areset(areset), .r(r), .g(g), .b(b),
    .valid(valid), .sof(sof), .eol(eol), .in_stream_ready(in_stream_ready),
    .out_stream_tdata(tdata), .out_stream_tkeep(tkeep), .out_stream_tlast(tlast),
    .out_stream_tuser(tuser), .out_stream_tvalid(tvalid), .out_stream_tready(tready),
    .sync_err(sync_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  int words_seen = 0;
  int ready_drops = 0;

  // scoreboard: {tuser, tlast, tkeep, tdata}
  logic [37:0] exp_q[$];
  // reference model: bytes received but not yet in a word
  logic [7:0]  pend_q[$];
  bit          m_user = 1'b0;
  bit          m_sync_err = 1'b0;

  bit   tr_rand = 1'b0;
  logic tr_fixed = 1'b1;

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge aclk);
      #2;
      tready = tr_rand ? 1'($urandom_range(0, 1)) : tr_fixed;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic emit_word(input int n, input bit last);
    logic [31:0] d;
    logic [3:0]  k;
    d = '0;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        d[8*i +: 8] = pend_q.pop_front();
        k[i] = 1'b1;
      end else begin
        d[8*i +: 8] = PAD;
      end
    end
    exp_q.push_back({m_user, last, k, d});
    m_user = 1'b0;
  endtask

  task automatic model_accept(input logic [23:0] px, input bit s, input bit e);
    if (s) begin
      if (pend_q.size() != 0) m_sync_err = 1'b1;
      pend_q.delete();
      m_user = 1'b1;
    end
    for (int i = 0; i < 3; i++) pend_q.push_back(px[8*i +: 8]);
    while (pend_q.size() >= 4) emit_word(4, e && (pend_q.size() == 4));
    if (e && (pend_q.size() != 0)) emit_word(pend_q.size(), 1'b1);
  endtask

  // ---------------- driver tasks (entered and left on a falling edge) ----------------
  task automatic send_px(input logic [23:0] px, input bit s, input bit e);
    int n;
    n = 0;
    {r, g, b} = px;
    sof = s;
    eol = e;
    valid = 1'b1;
    if (!in_stream_ready) ready_drops++;
    while (!in_stream_ready && n < 500) begin
      @(negedge aclk);
      n++;
    end
    if (!in_stream_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=ready_low required=ready_high");
      valid = 1'b0;
    end else begin
      model_accept(px, s, e);
      @(negedge aclk);
    end
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    sof = 1'b0;
    eol = 1'b0;
    repeat (n) @(negedge aclk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle(1);
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    check("drain_words_left", exp_q.size(), 0);
  endtask

  task automatic frame_abcd();
    send_px(24'h112233, 1'b1, 1'b0);
    send_px(24'h445566, 1'b0, 1'b0);
    send_px(24'h778899, 1'b0, 1'b0);
    send_px(24'hAABBCC, 1'b0, 1'b1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic        stall_prev;
    logic [37:0] held, cur, e;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge aclk);
      cur = {tuser, tlast, tkeep, tdata};
      if (areset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) check("held_word_stable", cur, held);
        stall_prev = tvalid && !tready;
        held = cur;
        if (tvalid && tready) begin
          words_seen++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word actual=%0h required=none", cur);
          end else begin
            e = exp_q.pop_front();
            check("word", cur, e);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int w0, len;
    areset = 1'b1;
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
    r = '0; g = '0; b = '0;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);

    // reset state
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tkeep", tkeep, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tuser", tuser, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_dbg_state", dbg_state, 0);
    check("rst_ready", in_stream_ready, 1);

    // four-pixel frame, tready high
    frame_abcd();
    drain();

    // 640-pixel line with continuous valid
    w0 = words_seen;
    ready_drops = 0;
    for (int i = 0; i < 640; i++) send_px(24'($urandom), i == 0, i == 639);
    drain();
    check("line640_words", words_seen - w0, 480);
    check("line640_ready_drops", ready_drops, 0);

    // four-pixel frame with tready toggling
    tr_rand = 1'b1;
    frame_abcd();
    drain();
    tr_rand = 1'b0;
    idle(2);

    // two-pixel line: full word, then flush word with ready low
    send_px(24'h112233, 1'b1, 1'b0);
    send_px(24'h445566, 1'b0, 1'b1);
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
    check("flush_ready_low", in_stream_ready, 0);
    check("flush_state", dbg_state[2], 1);
    drain();

    // sof on the third pixel of a group
    send_px(24'h010203, 1'b1, 1'b0);
    send_px(24'h040506, 1'b0, 1'b0);
    send_px(24'h070809, 1'b1, 1'b0);
    check("sync_err_set", sync_err, m_sync_err);
    send_px(24'h0A0B0C, 1'b0, 1'b0);
    send_px(24'h0D0E0F, 1'b0, 1'b0);
    send_px(24'h101112, 1'b0, 1'b1);
    drain();
    check("sync_err_sticky", sync_err, m_sync_err);

    // reset while the flush word is waiting
    tr_fixed = 1'b0;
    idle(2);
    send_px(24'h112233, 1'b1, 1'b0);
    send_px(24'h445566, 1'b0, 1'b1);
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
    check("pre_reset_in_flush", dbg_state[2], 1);
    areset = 1'b1;
    @(negedge aclk);
    check("mid_flush_rst_tvalid", tvalid, 0);
    check("mid_flush_rst_state", dbg_state, 0);
    check("mid_flush_rst_sync_err", sync_err, 0);
    @(negedge aclk);
    areset = 1'b0;
    exp_q.delete();
    pend_q.delete();
    m_user = 1'b0;
    m_sync_err = 1'b0;
    tr_fixed = 1'b1;
    idle(2);
    frame_abcd();
    drain();

    // random lines, random backpressure and gaps
    tr_rand = 1'b1;
    for (int ln = 0; ln < 40; ln++) begin
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        send_px(24'($urandom),
                (i == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0),
                i == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      check("rand_sync_err", sync_err, m_sync_err);
    end
    drain();
    tr_rand = 1'b0;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
